// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: captures 16 words of one block, then streams W0..W63
// from a 16-word sliding window, one word per valid/ready transfer.
module sha256_msg_schedule #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int ROUNDS          = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [7:0]            MP_counter_in,
  input  logic                  MP_dv_in,
  output logic [DATA_WIDTH-1:0] W_out,
  output logic [5:0]            W_idx_out,
  output logic                  W_dv_out,
  input  logic                  W_ready_in,
  output logic                  busy_out,
  output logic                  block_done_out
);

  // Handshake: a schedule word moves when W_dv_out && W_ready_in at a rising clk edge;
  // while W_ready_in is low, W_out/W_idx_out hold. Input words are accepted only when busy_out is low.

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                       state, state_nxt;
  logic [DATA_WIDTH-1:0]        win [WORDS_PER_BLOCK];
  logic [WORDS_PER_BLOCK-1:0]   mask;
  logic [5:0]                   t;
  logic                         done_q;

  logic                         load_hit;
  logic [3:0]                   load_idx;
  logic                         mask_full;
  logic                         xfer;
  logic                         last;
  logic [DATA_WIDTH-1:0]        new_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign load_idx  = MP_counter_in[3:0];
  assign load_hit  = (state == LOAD) && MP_dv_in && (MP_counter_in < 8'(WORDS_PER_BLOCK));
  assign mask_full = &mask;
  assign xfer      = (state == EMIT) && W_ready_in;
  assign last      = (t == 6'(ROUNDS - 1));

  // Single expansion path, always fed from the registered (pre-shift) window.
  assign new_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (mask_full) state_nxt = EMIT;
      EMIT:    if (xfer && last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      mask   <= '0;
      t      <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) win[i] <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= xfer && last;
      // Last write wins, so a packer holding a word for several cycles is harmless.
      if (load_hit) begin
        win[load_idx]  <= data_in;
        mask[load_idx] <= 1'b1;
      end
      if ((state == LOAD) && mask_full) t <= '0;
      if (xfer) begin
        if (last) begin
          mask <= '0;
          t    <= '0;
        end else begin
          for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) win[i] <= win[i+1];
          win[WORDS_PER_BLOCK-1] <= new_word;
          t <= t + 6'd1;
        end
      end
    end
  end

  assign W_out          = (state == EMIT) ? win[0] : '0;
  assign W_idx_out      = t;
  assign W_dv_out       = (state == EMIT);
  assign busy_out       = (state == EMIT);
  assign block_done_out = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: reference schedule model feeds an
// expected queue that a negedge monitor drains on every transfer.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  MP_counter_in = '0;
  logic        MP_dv_in = 1'b0;
  logic        W_ready_in = 1'b1;
  logic [31:0] W_out;
  logic [5:0]  W_idx_out;
  logic        W_dv_out;
  logic        busy_out;
  logic        block_done_out;

  int          total = 0;
  int          bad = 0;
  logic [37:0] exp_q[$];
  logic [31:0] blk[16];
  logic [31:0] sched[64];
  logic [31:0] obs_w[64];

  sha256_msg_schedule dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .MP_counter_in  (MP_counter_in),
    .MP_dv_in       (MP_dv_in),
    .W_out          (W_out),
    .W_idx_out      (W_idx_out),
    .W_dv_out       (W_dv_out),
    .W_ready_in     (W_ready_in),
    .busy_out       (busy_out),
    .block_done_out (block_done_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference schedule built from the full 64-entry recurrence.
  task automatic build_and_push();
    for (int i = 0; i < 16; i++) sched[i] = blk[i];
    for (int i = 16; i < 64; i++)
      sched[i] = ss1(sched[i-2]) + sched[i-7] + ss0(sched[i-15]) + sched[i-16];
    for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), sched[i]});
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    MP_dv_in      = 1'b1;
    MP_counter_in = 8'(idx);
    data_in       = d;
    step();
    MP_dv_in      = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) load_word(i, blk[i]);
  endtask

  // Called at the sample right after the final missing index was written.
  task automatic run_block(input int stall_a, input int stall_b, input int busy_at, output int cycles);
    int  stall_left;
    int  stall_idx;
    bit  sa, sb, bd, done, stalled;
    stall_left = 0; stall_idx = 0;
    sa = 0; sb = 0; bd = 0; done = 0;
    cycles = 0;
    check("latency_low", 32'(W_dv_out), 32'd0);
    step();
    check("latency_rise", 32'(W_dv_out), 32'd1);
    check("first_idx", 32'(W_idx_out), 32'd0);
    while (!done && cycles < 300) begin
      if (stall_left == 0 && W_dv_out) begin
        if (!sa && int'(W_idx_out) == stall_a) begin sa = 1; stall_left = 3; stall_idx = stall_a; end
        else if (!sb && int'(W_idx_out) == stall_b) begin sb = 1; stall_left = 3; stall_idx = stall_b; end
      end
      stalled = (stall_left > 0);
      W_ready_in = !stalled;
      if (stalled) stall_left--;
      if (!bd && W_dv_out && int'(W_idx_out) == busy_at) begin
        bd = 1;
        check("busy_during_emit", 32'(busy_out), 32'd1);
        MP_dv_in      = 1'b1;
        MP_counter_in = 8'd3;
        data_in       = 32'hFFFFFFFF;
      end
      step();
      cycles++;
      MP_dv_in = 1'b0;
      if (stalled) begin
        check("stall_idx", 32'(W_idx_out), 32'(stall_idx));
        check("stall_word", W_out, sched[stall_idx]);
      end
      if (block_done_out) done = 1;
    end
    W_ready_in = 1'b1;
    check("block_done_seen", 32'(done), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: a transfer happens at the next posedge when dv && ready here.
  always @(negedge clk) begin
    logic [37:0] e;
    if (rst_n && W_dv_out && W_ready_in) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("w_idx", 32'(W_idx_out), 32'(e[37:32]));
        check("w_word", W_out, e[31:0]);
        obs_w[W_idx_out] = W_out;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) obs_w[i] = '0;

    // Reset values
    step(); step();
    check("rst_w_out", W_out, 32'd0);
    check("rst_w_idx", 32'(W_idx_out), 32'd0);
    check("rst_w_dv", 32'(W_dv_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(block_done_out), 32'd0);
    rst_n = 1'b1;
    step();

    // Scenario 1: "abc" block, full throughput
    set_abc();
    build_and_push();
    load_all();
    run_block(-1, -1, -1, cyc);
    check("throughput_cycles", 32'(cyc), 32'd64);
    check("abc_w0", obs_w[0], 32'h61626380);
    check("abc_w15", obs_w[15], 32'h00000018);
    check("abc_w16", obs_w[16], 32'h61626380);
    check("abc_w17", obs_w[17], 32'h000F0000);
    check("abc_w18", obs_w[18], 32'h7DA86405);
    step();
    check("done_one_cycle", 32'(block_done_out), 32'd0);
    check("idle_dv", 32'(W_dv_out), 32'd0);
    check("idle_busy", 32'(busy_out), 32'd0);

    // Scenario 2: duplicate index 0 (last write wins), rest in reverse order
    set_abc();
    build_and_push();
    load_word(0, 32'h12345678);
    load_word(0, blk[0]);
    for (int i = 15; i >= 1; i--) load_word(i, blk[i]);
    run_block(-1, -1, -1, cyc);
    check("reorder_cycles", 32'(cyc), 32'd64);

    // Scenario 3: backpressure at t=5 and t=40
    set_abc();
    build_and_push();
    load_all();
    run_block(5, 40, -1, cyc);
    check("stall_cycles", 32'(cyc), 32'd70);

    // Scenario 4: input pulse while busy, then next block loaded back-to-back without index 3
    set_abc();
    build_and_push();
    load_all();
    run_block(-1, -1, 10, cyc);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    for (int i = 0; i < 16; i++) if (i != 3) load_word(i, blk[i]);
    // Scenario 6: out-of-range counters are ignored
    load_word(16, 32'hDEADBEEF);
    load_word(255, 32'hCAFEF00D);
    for (int k = 0; k < 3; k++) begin
      check("mask_excludes_3_dv", 32'(W_dv_out), 32'd0);
      check("mask_excludes_3_busy", 32'(busy_out), 32'd0);
      step();
    end
    build_and_push();
    load_word(3, blk[3]);
    run_block(-1, -1, -1, cyc);
    check("random_cycles", 32'(cyc), 32'd64);

    // Scenario 5: asynchronous reset at t=20, then a fresh "abc" block
    set_abc();
    build_and_push();
    load_all();
    step();
    for (int k = 0; k < 60; k++) begin
      if (W_dv_out && W_idx_out == 6'd20) break;
      step();
    end
    check("reached_t20", 32'(W_idx_out), 32'd20);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_w_out", W_out, 32'd0);
    check("arst_w_idx", 32'(W_idx_out), 32'd0);
    check("arst_w_dv", 32'(W_dv_out), 32'd0);
    check("arst_busy", 32'(busy_out), 32'd0);
    check("arst_done", 32'(block_done_out), 32'd0);
    step(); step();
    check("held_rst_dv", 32'(W_dv_out), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_dv", 32'(W_dv_out), 32'd0);
    for (int i = 0; i < 64; i++) obs_w[i] = '0;
    set_abc();
    build_and_push();
    load_all();
    run_block(-1, -1, -1, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd64);
    check("post_rst_w17", obs_w[17], 32'h000F0000);
    check("post_rst_w18", obs_w[18], 32'h7DA86405);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
Downstream stage of Message_Packer. It captures the 16 padded 32-bit words of one 512-bit block and expands them into the 64-word SHA-256 message schedule W0..W63. It emits one word per accepted handshake to the compression core. A 16-entry sliding window holds the words, so no 64-word RAM is required.

Parameters:
DATA_WIDTH, 32, word width; only 32 is supported.
WORDS_PER_BLOCK, 16, input words per block.
ROUNDS, 64, schedule words emitted per block.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
data_in  in  DATA_WIDTH  word from Message_Packer (data_out).
MP_counter_in  in  8  word index from Message_Packer (MP_counter_out).
MP_dv_in  in  1  word-valid from Message_Packer (MP_dv_out).
W_out  out  DATA_WIDTH  current schedule word Wt.
W_idx_out  out  6  index t of W_out.
W_dv_out  out  1  W_out valid.
W_ready_in  in  1  downstream accepts W_out this cycle.
busy_out  out  1  high in EMIT; input is ignored while high.
block_done_out  out  1  one-cycle pulse after W63 is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: every window word = 0, load mask = 0, t = 0, state = LOAD, W_out = 0, W_idx_out = 0, W_dv_out = 0, busy_out = 0, block_done_out = 0.
- Reset mid-operation: asserting rst_n low in any state aborts the block immediately. Nothing partial is emitted afterwards.
- State LOAD:
  - On a clk edge with MP_dv_in = 1 and MP_counter_in < 16, win[MP_counter_in[3:0]] <= data_in and mask bit [MP_counter_in] <= 1.
  - MP_counter_in >= 16 is ignored.
  - Repeated writes to the same index overwrite; last write wins. This tolerates the packer holding a word for more than one cycle.
  - When the mask becomes 16'hFFFF, go to EMIT on the next edge with t = 0.
- State EMIT:
  - W_out = win[0], W_idx_out = t, W_dv_out = 1, busy_out = 1.
  - Latency: W_dv_out rises on the edge after the cycle in which the final mask bit is set.
  - Handshake: a word transfers when W_dv_out && W_ready_in at a clk edge.
  - When W_ready_in = 0, W_out and W_idx_out hold stable; there is no bubble or skip.
  - On transfer with t < 63: win[i] <= win[i+1] for i = 0..14, win[15] <= new word, t <= t+1.
  - New word = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32, using the pre-shift window.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - The window is computed for t+16 > 63 too, but those values are never emitted.
  - On transfer with t = 63: go to LOAD, clear the mask, t <= 0, W_dv_out <= 0, busy_out <= 0, block_done_out <= 1 for one cycle.
- MP_dv_in while busy_out = 1 is dropped and does not touch the window or mask. Upstream must wait for busy_out = 0.
- Back-to-back blocks: a word arriving in the same cycle as the block_done_out pulse is captured, because the state is already LOAD.
- Throughput: with W_ready_in held high, the block emits 64 words in 64 consecutive cycles.
- Expansion logic: exactly one σ0/σ1/3-adder path, driven from the registered window.

Test Plan:
1. "abc" block: stream 61626380, 0×14, 00000018 with counters 0..15 and W_ready_in = 1. Expect W0 = 61626380, W15 = 00000018, W16 = 61626380, W17 = 000F0000, W18 = 7DA86405. Expect W_idx_out to increment 0..63 on consecutive cycles, then block_done_out high for exactly one cycle.
2. Duplicate and out-of-order load: word 0 presented twice, then indices written in the order 15..1. Expect a schedule identical to scenario 1, with W_dv_out rising one cycle after the last missing index is written.
3. Backpressure: drop W_ready_in for 3 cycles at t = 5 and t = 40. Expect W_out and W_idx_out to hold during the stalls and the full sequence to equal scenario 1 with no duplicates or skips.
4. Busy input: pulse MP_dv_in with counter 3 and data FFFFFFFF during EMIT. Expect the current schedule unchanged and the next block's mask not to include index 3.
5. Reset: assert rst_n at t = 20. Expect every output at its reset value asynchronously. A fresh "abc" load afterwards reproduces scenario 1.
6. Counter out of range: MP_dv_in with counter 16 and 255. Expect no window or mask change and the state to remain LOAD.
